// File: rtl/lsu_initiator.sv
// Load/store initiator between the execute stage and a byte-addressed data RAM.
// Aligned requests take one RAM cycle; misaligned halves/words become byte sequences.
module lsu_initiator #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_access,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        mem_load,
    output logic        mem_store,
    output logic [2:0]  mem_access,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam logic [2:0] ACC_LB  = 3'b000;
    localparam logic [2:0] ACC_LH  = 3'b001;
    localparam logic [2:0] ACC_LW  = 3'b010;
    localparam logic [2:0] ACC_LBU = 3'b100;
    localparam logic [2:0] ACC_LHU = 3'b101;

    typedef enum logic [1:0] {IDLE, ISSUE, SPLIT, RESP} state_t;

    state_t      state;
    logic        lat_load;
    logic        lat_store;
    logic [2:0]  lat_access;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  idx;
    logic [31:0] asm_data;

    logic        req_bad;
    logic        req_mis;
    logic        split_last;
    logic [1:0]  idx_next;
    logic [31:0] addr_next;
    logic [31:0] wdata_next;
    logic [31:0] asm_next;

    // Half/word results assembled from byte reads need their own extension.
    function automatic logic [31:0] extend_load(input logic [2:0] access, input logic [31:0] raw);
        logic signed [15:0] half;
        half = raw[15:0];
        case (access)
            ACC_LH:  return 32'(half);
            ACC_LHU: return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign req_ready = (state == IDLE);

    always_comb begin
        req_bad = 1'b0;
        req_mis = 1'b0;
        if (req_load == req_store)
            req_bad = 1'b1;
        else if (req_load)
            req_bad = !(req_access inside {ACC_LB, ACC_LH, ACC_LW, ACC_LBU, ACC_LHU});
        else
            req_bad = !(req_access inside {ACC_LB, ACC_LH, ACC_LW});
        case (req_access[1:0])
            2'b01:   req_mis = req_addr[0];
            2'b10:   req_mis = |req_addr[1:0];
            default: req_mis = 1'b0;
        endcase
    end

    always_comb begin
        split_last = lat_access[1] ? (idx == 2'd3) : (idx == 2'd1);
        idx_next   = idx + 2'd1;
        addr_next  = lat_addr + {30'd0, idx_next};
        wdata_next = lat_wdata >> {idx_next, 3'b000};
        asm_next   = asm_data;
        asm_next[{idx, 3'b000} +: 8] = mem_data_out[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lat_load    <= 1'b0;
            lat_store   <= 1'b0;
            lat_access  <= 3'd0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            idx         <= 2'd0;
            asm_data    <= 32'd0;
            resp_valid  <= 1'b0;
            resp_data   <= 32'd0;
            resp_err    <= 1'b0;
            mem_load    <= 1'b0;
            mem_store   <= 1'b0;
            mem_access  <= 3'd0;
            mem_addr    <= 32'd0;
            mem_data_in <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid) begin
                        lat_load   <= req_load;
                        lat_store  <= req_store;
                        lat_access <= req_access;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        idx        <= 2'd0;
                        asm_data   <= 32'd0;
                        if (req_bad || (req_mis && !SPLIT_MISALIGNED)) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 32'd0;
                        end else if (req_mis) begin
                            state       <= SPLIT;
                            mem_load    <= req_load;
                            mem_store   <= req_store;
                            mem_access  <= req_store ? ACC_LB : ACC_LBU;
                            mem_addr    <= req_addr;
                            mem_data_in <= req_store ? req_wdata : 32'd0;
                        end else begin
                            state       <= ISSUE;
                            mem_load    <= req_load;
                            mem_store   <= req_store;
                            mem_access  <= req_access;
                            mem_addr    <= req_addr;
                            mem_data_in <= req_wdata;
                        end
                    end
                end
                ISSUE: begin
                    // RAM read is combinational, so the word is captured at the end of the strobe cycle.
                    mem_load    <= 1'b0;
                    mem_store   <= 1'b0;
                    mem_access  <= 3'd0;
                    mem_addr    <= 32'd0;
                    mem_data_in <= 32'd0;
                    resp_data   <= lat_load ? mem_data_out : 32'd0;
                    resp_err    <= 1'b0;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                SPLIT: begin
                    asm_data <= asm_next;
                    if (split_last) begin
                        mem_load    <= 1'b0;
                        mem_store   <= 1'b0;
                        mem_access  <= 3'd0;
                        mem_addr    <= 32'd0;
                        mem_data_in <= 32'd0;
                        resp_data   <= lat_load ? extend_load(lat_access, asm_next) : 32'd0;
                        resp_err    <= 1'b0;
                        resp_valid  <= 1'b1;
                        state       <= RESP;
                    end else begin
                        idx         <= idx_next;
                        mem_addr    <= addr_next;
                        mem_data_in <= lat_store ? wdata_next : 32'd0;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_initiator.sv
// Scoreboard bench for lsu_initiator: byte RAM model, expected RAM cycles and responses queued per request.
module tb_lsu_initiator;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_valid0;
    logic        req_load, req_store;
    logic [2:0]  req_access;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_data;
    logic        mem_load, mem_store;
    logic [2:0]  mem_access;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;

    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_data0;
    logic        mem_load0, mem_store0;
    logic [2:0]  mem_access0;
    logic [31:0] mem_addr0, mem_data_in0;
    logic [31:0] mem_data_out0;
    assign mem_data_out0 = 32'h5A5A_5A5A;

    lsu_initiator #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store), .req_access(req_access),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_load(mem_load), .mem_store(mem_store), .mem_access(mem_access),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    lsu_initiator #(.SPLIT_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_load(req_load), .req_store(req_store), .req_access(req_access),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_data(resp_data0), .resp_err(resp_err0),
        .mem_load(mem_load0), .mem_store(mem_store0), .mem_access(mem_access0),
        .mem_addr(mem_addr0), .mem_data_in(mem_data_in0), .mem_data_out(mem_data_out0)
    );

    // Byte RAM model (256 bytes, address wraps on the low 8 bits), little-endian.
    logic [7:0] ram [0:255] = '{default: 8'h00};
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;
    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    assign a0 = mem_addr[7:0];
    assign a1 = a0 + 8'd1;
    assign a2 = a0 + 8'd2;
    assign a3 = a0 + 8'd3;

    always_comb begin
        b0 = ram[a0];
        b1 = ram[a1];
        b2 = ram[a2];
        b3 = ram[a3];
        case (mem_access)
            3'b000:  mem_data_out = {{24{b0[7]}}, b0};
            3'b100:  mem_data_out = {24'd0, b0};
            3'b001:  mem_data_out = {{16{b1[7]}}, b1, b0};
            3'b101:  mem_data_out = {16'd0, b1, b0};
            3'b010:  mem_data_out = {b3, b2, b1, b0};
            default: mem_data_out = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        if (mem_store) begin
            case (mem_access[1:0])
                2'b00: ram[a0] <= mem_data_in[7:0];
                2'b01: begin
                    ram[a0] <= mem_data_in[7:0];
                    ram[a1] <= mem_data_in[15:8];
                end
                2'b10: begin
                    ram[a0] <= mem_data_in[7:0];
                    ram[a1] <= mem_data_in[15:8];
                    ram[a2] <= mem_data_in[23:16];
                    ram[a3] <= mem_data_in[31:24];
                end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  acc;
        logic [31:0] addr;
        logic [31:0] din;
    } memop_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } resp_t;

    memop_t exp_q[$];
    resp_t  resp_q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after RESP.
    task automatic do_txn(input string nm, input logic ld, input logic st, input logic [2:0] acc,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_data);
        memop_t e;
        resp_t  r;
        resp_t  got;
        logic   bad, mis;
        int     n;
        bit     done;
        bad = (ld == st) || (ld && (acc == 3'b011 || acc[2:1] == 2'b11)) || (st && acc > 3'b010);
        mis = (acc[1:0] == 2'b01 && addr[0]) || (acc[1:0] == 2'b10 && addr[1:0] != 2'b00);
        r.data = exp_data;
        r.err = bad;
        if (bad) begin
            r.lat = 1;
        end else if (!mis) begin
            e.ld = ld; e.st = st; e.acc = acc; e.addr = addr; e.din = wd;
            exp_q.push_back(e);
            r.lat = 2;
        end else begin
            n = acc[1] ? 4 : 2;
            for (int i = 0; i < n; i++) begin
                e.ld = ld; e.st = st; e.acc = st ? 3'b000 : 3'b100;
                e.addr = addr + 32'(i);
                e.din = st ? (wd >> (8 * i)) : 32'd0;
                exp_q.push_back(e);
            end
            r.lat = n + 1;
        end
        resp_q.push_back(r);

        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_idle: got %b want 1", nm, req_ready);
        end
        req_load = ld; req_store = st; req_access = acc; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_load = 1'($urandom); req_store = 1'($urandom); req_access = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;

        done = 1'b0;
        for (int cyc = 1; cyc <= 10 && !done; cyc++) begin
            @(negedge clk);
            vectors++;
            if (mem_load || mem_store) begin
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s unexpected_strobe cyc%0d: got ld=%b st=%b addr=%h want none",
                             nm, cyc, mem_load, mem_store, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_load, mem_store, mem_access, mem_addr, mem_data_in} !==
                        {e.ld, e.st, e.acc, e.addr, e.din}) begin
                        miscompares++;
                        $display("FAIL %s mem_cycle cyc%0d: got ld=%b st=%b acc=%b addr=%h din=%h want ld=%b st=%b acc=%b addr=%h din=%h",
                                 nm, cyc, mem_load, mem_store, mem_access, mem_addr, mem_data_in,
                                 e.ld, e.st, e.acc, e.addr, e.din);
                    end
                end
            end else if ({mem_access, mem_addr, mem_data_in} !== 67'd0) begin
                miscompares++;
                $display("FAIL %s mem_idle cyc%0d: got acc=%b addr=%h din=%h want 0",
                         nm, cyc, mem_access, mem_addr, mem_data_in);
            end
            vectors++;
            if (req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s ready_busy cyc%0d: got %b want 0", nm, cyc, req_ready);
            end
            if (resp_valid === 1'b1) begin
                got = resp_q.pop_front();
                done = 1'b1;
                vectors++;
                if (cyc != got.lat) begin
                    miscompares++;
                    $display("FAIL %s latency: got %0d want %0d", nm, cyc, got.lat);
                end
                vectors++;
                if ({resp_err, resp_data} !== {got.err, got.data}) begin
                    miscompares++;
                    $display("FAIL %s resp: got err=%b data=%h want err=%b data=%h",
                             nm, resp_err, resp_data, got.err, got.data);
                end
            end else begin
                @(posedge clk);
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: got no resp_valid want resp within 10 cycles", nm);
            void'(resp_q.pop_front());
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s missing_mem_cycles: got %0d left want 0", nm, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0; req_valid0 = 1'b0;
        req_load = 1'b0; req_store = 1'b0; req_access = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({req_ready, resp_valid, resp_err, resp_data} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_resp: got rdy=%b vld=%b err=%b data=%h want 1 0 0 0",
                     req_ready, resp_valid, resp_err, resp_data);
        end
        vectors++;
        if ({mem_load, mem_store, mem_access, mem_addr, mem_data_in} !== 69'd0) begin
            miscompares++;
            $display("FAIL reset_mem: got ld=%b st=%b acc=%b addr=%h din=%h want all 0",
                     mem_load, mem_store, mem_access, mem_addr, mem_data_in);
        end
        vectors++;
        if ({req_ready0, resp_valid0, resp_err0, resp_data0, mem_load0, mem_store0,
             mem_access0, mem_addr0, mem_data_in0} !== {1'b1, 103'd0}) begin
            miscompares++;
            $display("FAIL reset_nosplit: got rdy=%b vld=%b st=%b addr=%h want rdy 1 rest 0",
                     req_ready0, resp_valid0, mem_store0, mem_addr0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_aligned;
        poke(8'h10, 8'hEF); poke(8'h11, 8'hBE); poke(8'h12, 8'hAD); poke(8'h13, 8'hDE);
        do_txn("lw_aligned",  1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF);
        do_txn("lb_aligned",  1, 0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFEF);
        do_txn("lbu_aligned", 1, 0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE);
        do_txn("lh_aligned",  1, 0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD);
        do_txn("lhu_aligned", 1, 0, 3'b101, 32'h10, 32'hCAFE_0000, 32'h0000_BEEF);
    endtask

    task automatic test_split_store;
        do_txn("sw_split",     0, 1, 3'b010, 32'h21, 32'h1122_3344, 32'h0);
        do_txn("lw_after_sw",  1, 0, 3'b010, 32'h20, 32'h0, 32'h2233_4400);
        do_txn("sh_split",     0, 1, 3'b001, 32'h31, 32'hFFFF_ABCD, 32'h0);
        do_txn("lhu_after_sh", 1, 0, 3'b101, 32'h31, 32'h0, 32'h0000_ABCD);
        do_txn("lh_after_sh",  1, 0, 3'b001, 32'h31, 32'h0, 32'hFFFF_ABCD);
        do_txn("lw_around_sh", 1, 0, 3'b010, 32'h30, 32'h0, 32'h00AB_CD00);
    endtask

    task automatic test_split_load;
        poke(8'h03, 8'h80); poke(8'h04, 8'hFF);
        do_txn("lh_split",  1, 0, 3'b001, 32'h03, 32'h0, 32'hFFFF_FF80);
        do_txn("lhu_split", 1, 0, 3'b101, 32'h03, 32'h0, 32'h0000_FF80);
        do_txn("lw_split",  1, 0, 3'b010, 32'h11, 32'h0, 32'h00DE_ADBE);
    endtask

    task automatic test_errors;
        do_txn("err_ld_and_st", 1, 1, 3'b010, 32'h10, 32'h0, 32'h0);
        do_txn("err_neither",   0, 0, 3'b010, 32'h10, 32'h0, 32'h0);
        do_txn("err_load_011",  1, 0, 3'b011, 32'h10, 32'h0, 32'h0);
        do_txn("err_load_111",  1, 0, 3'b111, 32'h10, 32'h0, 32'h0);
        do_txn("err_store_100", 0, 1, 3'b100, 32'h10, 32'h1234_5678, 32'h0);
    endtask

    task automatic test_wrap;
        do_txn("sw_wrap", 0, 1, 3'b010, 32'hFFFF_FFFF, 32'hA1B2_C3D4, 32'h0);
        vectors++;
        if ({ram[8'hFF], ram[8'h00], ram[8'h01], ram[8'h02]} !== 32'hD4C3_B2A1) begin
            miscompares++;
            $display("FAIL wrap_bytes: got %h %h %h %h want d4 c3 b2 a1",
                     ram[8'hFF], ram[8'h00], ram[8'h01], ram[8'h02]);
        end
        do_txn("lw_after_wrap", 1, 0, 3'b010, 32'h0, 32'h0, 32'h80A1_B2C3);
    endtask

    task automatic test_no_split;
        @(negedge clk);
        req_load = 1'b0; req_store = 1'b1; req_access = 3'b010;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h1111_2222;
        req_valid0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        @(negedge clk);
        vectors++;
        if ({resp_valid0, resp_err0, resp_data0, mem_load0, mem_store0} !== {1'b1, 1'b1, 32'd0, 2'b00}) begin
            miscompares++;
            $display("FAIL nosplit_err: got vld=%b err=%b data=%h ld=%b st=%b want 1 1 0 0 0",
                     resp_valid0, resp_err0, resp_data0, mem_load0, mem_store0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        req_load = 1'b1; req_store = 1'b0; req_access = 3'b010; req_addr = 32'h0;
        req_valid0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_load0, mem_store0, mem_access0, mem_addr0, resp_valid0} !== {2'b10, 3'b010, 32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL nosplit_issue: got ld=%b st=%b acc=%b addr=%h vld=%b want 1 0 010 0 0",
                     mem_load0, mem_store0, mem_access0, mem_addr0, resp_valid0);
        end
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({resp_valid0, resp_err0, resp_data0} !== {1'b1, 1'b0, 32'h5A5A_5A5A}) begin
            miscompares++;
            $display("FAIL nosplit_resp: got vld=%b err=%b data=%h want 1 0 5a5a5a5a",
                     resp_valid0, resp_err0, resp_data0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        do_txn("b2b_sb",  0, 1, 3'b000, 32'h50, 32'h1234_565A, 32'h0);
        do_txn("b2b_lbu", 1, 0, 3'b100, 32'h50, 32'h0, 32'h0000_005A);
        do_txn("b2b_lw",  1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({resp_valid, resp_data} !== {1'b0, 32'hDEAD_BEEF}) begin
                miscompares++;
                $display("FAIL hold_resp cyc%0d: got vld=%b data=%h want 0 deadbeef", i, resp_valid, resp_data);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_load = 1'b0; req_store = 1'b1; req_access = 3'b010;
        req_addr = 32'h41; req_wdata = 32'h1122_3344;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_store, mem_addr} !== {1'b1, 32'h41}) begin
            miscompares++;
            $display("FAIL rstmid_byte0: got st=%b addr=%h want 1 00000041", mem_store, mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_store, mem_addr} !== {1'b1, 32'h42}) begin
            miscompares++;
            $display("FAIL rstmid_byte1: got st=%b addr=%h want 1 00000042", mem_store, mem_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({mem_load, mem_store, resp_valid, req_ready, resp_data} !== {4'b0001, 32'd0}) begin
                miscompares++;
                $display("FAIL rstmid_after cyc%0d: got ld=%b st=%b vld=%b rdy=%b data=%h want 0 0 0 1 0",
                         i, mem_load, mem_store, resp_valid, req_ready, resp_data);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if ({ram[8'h41], ram[8'h42], ram[8'h43], ram[8'h44]} !== 32'h4433_0000) begin
            miscompares++;
            $display("FAIL rstmid_ram: got %h %h %h %h want 44 33 00 00",
                     ram[8'h41], ram[8'h42], ram[8'h43], ram[8'h44]);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_split_store();
        test_split_load();
        test_errors();
        test_wrap();
        test_no_split();
        test_back_to_back();
        test_reset_mid();
        do_txn("after_reset_lw", 1, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
